// File: rtl/rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_scheduler
// Purpose  : Owns the single write port of the NREG x DW register file.
//            Arbitrates it round-robin between the ALU and MEM writeback
//            requesters using valid/ready handshakes. Keeps a per-register
//            pending-write scoreboard that decode uses for RAW/WAW stalls.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk               clock, all state on the rising edge
//   rst_n             synchronous reset, active low
//   alu_wb_valid_i    ALU writeback request
//   alu_wb_reg_i      ALU destination register
//   alu_wb_data_i     ALU result
//   alu_wb_ready_o    ALU request granted this cycle
//   mem_wb_valid_i    MEM (load) writeback request
//   mem_wb_reg_i      MEM destination register
//   mem_wb_data_i     load data
//   mem_wb_ready_o    MEM request granted this cycle
//   wb_hold_i         blocks all grants while high
//   issue_valid_i     decode issues an instruction with a destination
//   issue_reg_i       destination of the issuing instruction
//   issue_ready_o     issue accepted (no pending write to issue_reg_i)
//   src1_reg_i        decode source operand 1
//   src2_reg_i        decode source operand 2
//   src_busy_o        either source has a pending write
//   rf_we_o           register file write enable (registered)
//   rf_write_reg_o    register file write index (registered)
//   rf_write_data_o   register file write data (registered)
//   sb_err_o          sticky: write committed to a non-pending register
// ============================================================================
module rf_wb_scheduler #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int DW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_wb_valid_i,
  input  logic [AW-1:0] alu_wb_reg_i,
  input  logic [DW-1:0] alu_wb_data_i,
  output logic          alu_wb_ready_o,
  input  logic          mem_wb_valid_i,
  input  logic [AW-1:0] mem_wb_reg_i,
  input  logic [DW-1:0] mem_wb_data_i,
  output logic          mem_wb_ready_o,
  input  logic          wb_hold_i,
  input  logic          issue_valid_i,
  input  logic [AW-1:0] issue_reg_i,
  output logic          issue_ready_o,
  input  logic [AW-1:0] src1_reg_i,
  input  logic [AW-1:0] src2_reg_i,
  output logic          src_busy_o,
  output logic          rf_we_o,
  output logic [AW-1:0] rf_write_reg_o,
  output logic [DW-1:0] rf_write_data_o,
  output logic          sb_err_o
);

  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_MEM = 1'b1
  } last_grant_e;

  last_grant_e     last_grant_q, last_grant_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic            rf_we_q;
  logic [AW-1:0]   rf_write_reg_q;
  logic [DW-1:0]   rf_write_data_q;
  logic            sb_err_q, sb_err_d;

  logic            w_alu_gnt;
  logic            w_mem_gnt;
  logic            w_issue_fire;

  // Round-robin arbitration. Reset and wb_hold suppress every grant, so an
  // in-flight request is simply re-presented once they release.
  always_comb begin
    w_alu_gnt    = 1'b0;
    w_mem_gnt    = 1'b0;
    last_grant_d = last_grant_q;
    if (rst_n && !wb_hold_i) begin
      if (alu_wb_valid_i && mem_wb_valid_i) begin
        if (last_grant_q == LAST_MEM) begin
          w_alu_gnt = 1'b1;
        end else begin
          w_mem_gnt = 1'b1;
        end
      end else begin
        w_alu_gnt = alu_wb_valid_i;
        w_mem_gnt = mem_wb_valid_i;
      end
    end
    if (w_alu_gnt) begin
      last_grant_d = LAST_ALU;
    end else if (w_mem_gnt) begin
      last_grant_d = LAST_MEM;
    end
  end

  assign alu_wb_ready_o = w_alu_gnt;
  assign mem_wb_ready_o = w_mem_gnt;

  // Issue sees only the current scoreboard; a clear landing this edge is not
  // bypassed, so a WAW re-issue waits one extra cycle after the commit.
  assign issue_ready_o = rst_n && !pending_q[issue_reg_i];
  assign w_issue_fire  = issue_valid_i && issue_ready_o;

  // The clear of the committing register and the register file write share
  // an edge, so src_busy drops exactly when the new value becomes readable.
  assign src_busy_o = pending_q[src1_reg_i] | pending_q[src2_reg_i];

  always_comb begin
    pending_d = pending_q;
    sb_err_d  = sb_err_q;
    if (rf_we_q) begin
      if (!pending_q[rf_write_reg_q]) begin
        sb_err_d = 1'b1;
      end
      pending_d[rf_write_reg_q] = 1'b0;
    end
    // Applied after the clear so that a set of the same register wins.
    if (w_issue_fire) begin
      pending_d[issue_reg_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q    <= LAST_MEM;
      pending_q       <= '0;
      rf_we_q         <= 1'b0;
      rf_write_reg_q  <= '0;
      rf_write_data_q <= '0;
      sb_err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      sb_err_q     <= sb_err_d;
      rf_we_q      <= w_alu_gnt | w_mem_gnt;
      // Index and data hold their last values when nothing is granted.
      if (w_alu_gnt) begin
        rf_write_reg_q  <= alu_wb_reg_i;
        rf_write_data_q <= alu_wb_data_i;
      end else if (w_mem_gnt) begin
        rf_write_reg_q  <= mem_wb_reg_i;
        rf_write_data_q <= mem_wb_data_i;
      end
    end
  end

  assign rf_we_o         = rf_we_q;
  assign rf_write_reg_o  = rf_write_reg_q;
  assign rf_write_data_o = rf_write_data_q;
  assign sb_err_o        = sb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_scheduler
// Purpose  : Self-checking bench for rf_wb_scheduler: reset sequence, a
//            directed vector table for the multi-cycle corner cases, then
//            randomized traffic compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_scheduler;

  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int DW   = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_v, mem_v, hold, iss_v;
  logic [AW-1:0] alu_r, mem_r, iss_r, src1, src2;
  logic [DW-1:0] alu_d, mem_d;
  logic          alu_rdy, mem_rdy, iss_rdy, busy, we, err;
  logic [AW-1:0] wreg;
  logic [DW-1:0] wdata;

  always #5 clk = ~clk;

  rf_wb_scheduler #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_wb_valid_i (alu_v),
    .alu_wb_reg_i   (alu_r),
    .alu_wb_data_i  (alu_d),
    .alu_wb_ready_o (alu_rdy),
    .mem_wb_valid_i (mem_v),
    .mem_wb_reg_i   (mem_r),
    .mem_wb_data_i  (mem_d),
    .mem_wb_ready_o (mem_rdy),
    .wb_hold_i      (hold),
    .issue_valid_i  (iss_v),
    .issue_reg_i    (iss_r),
    .issue_ready_o  (iss_rdy),
    .src1_reg_i     (src1),
    .src2_reg_i     (src2),
    .src_busy_o     (busy),
    .rf_we_o        (we),
    .rf_write_reg_o (wreg),
    .rf_write_data_o(wdata),
    .sb_err_o       (err)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit            m_pend[NREG];
  bit            m_last_mem;
  bit            m_we;
  logic [AW-1:0] m_wreg;
  logic [DW-1:0] m_wdata;
  bit            m_err;
  int            last_win;

  function automatic void m_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_last_mem = 1'b1;
    m_we       = 1'b0;
    m_wreg     = '0;
    m_wdata    = '0;
    m_err      = 1'b0;
  endfunction

  // 0 = nobody, 1 = ALU, 2 = MEM
  function automatic int m_winner();
    if (!rst_n || hold) return 0;
    if (alu_v && mem_v) return m_last_mem ? 1 : 2;
    if (alu_v) return 1;
    if (mem_v) return 2;
    return 0;
  endfunction

  function automatic void m_advance();
    int  w;
    bit  accept;
    w      = m_winner();
    accept = iss_v && !m_pend[iss_r];
    if (!rst_n) begin
      m_reset();
    end else begin
      if (m_we) begin
        if (!m_pend[m_wreg]) m_err = 1'b1;
        m_pend[m_wreg] = 1'b0;
      end
      if (accept) m_pend[iss_r] = 1'b1;
      m_we = (w != 0);
      if (w == 1) begin
        m_wreg = alu_r; m_wdata = alu_d; m_last_mem = 1'b0;
      end else if (w == 2) begin
        m_wreg = mem_r; m_wdata = mem_d; m_last_mem = 1'b1;
      end
    end
  endfunction

  task automatic check_model(input bit regs);
    chk("alu_ready",   alu_rdy, (m_winner() == 1));
    chk("mem_ready",   mem_rdy, (m_winner() == 2));
    chk("issue_ready", iss_rdy, rst_n && !m_pend[iss_r]);
    if (regs) begin
      chk("src_busy", busy,  m_pend[src1] | m_pend[src2]);
      chk("rf_we",    we,    m_we);
      chk("rf_reg",   wreg,  m_wreg);
      chk("rf_data",  wdata, m_wdata);
      chk("sb_err",   err,   m_err);
    end
  endtask

  // Inputs are already driven; check at the falling edge, then close the cycle.
  task automatic run_cycle(input bit do_chk, input bit regs);
    @(negedge clk);
    if (do_chk) check_model(regs);
    @(posedge clk);
    last_win = m_winner();
    m_advance();
    cyc++;
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst, av, mv, hold, iv;
    logic [AW-1:0] ar, mr, ir, s1, s2;
    logic [DW-1:0] ad, md;
    logic          e_ar, e_mr, e_ir, e_busy, e_we, e_err;
    logic [AW-1:0] e_wreg;
    logic [DW-1:0] e_wd;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input int rst, input int av, input int ar, input int ad,
                     input int mv, input int mr, input int md, input int hl,
                     input int iv, input int ir, input int s1v, input int s2v,
                     input int ear, input int emr, input int eir, input int ebusy,
                     input int ewe, input int ewreg, input int ewd, input int eerr);
    vec_t v;
    v.rst = 1'(rst); v.av = 1'(av); v.ar = AW'(ar); v.ad = DW'(ad);
    v.mv = 1'(mv); v.mr = AW'(mr); v.md = DW'(md); v.hold = 1'(hl);
    v.iv = 1'(iv); v.ir = AW'(ir); v.s1 = AW'(s1v); v.s2 = AW'(s2v);
    v.e_ar = 1'(ear); v.e_mr = 1'(emr); v.e_ir = 1'(eir); v.e_busy = 1'(ebusy);
    v.e_we = 1'(ewe); v.e_wreg = AW'(ewreg); v.e_wd = DW'(ewd); v.e_err = 1'(eerr);
    vecs.push_back(v);
  endtask

  function automatic logic [AW-1:0] pick_reg();
    int q[$];
    foreach (m_pend[i]) if (m_pend[i]) q.push_back(i);
    if (q.size() > 0 && $urandom_range(0, 7) != 0)
      return AW'(q[$urandom_range(0, q.size() - 1)]);
    return AW'($urandom_range(0, NREG - 1));
  endfunction

  initial begin
    m_reset();
    last_win = 0;

    // rst    ALU            MEM            hold iss     src    | aR mR iR busy we wreg wdata err
    // Contention: first dual request after reset grants ALU, then alternates.
    add(1, 0,0,0,          0,0,0,          0, 1,1, 1,2,  0,0,1,0, 0,0,16'h0000,0);
    add(1, 0,0,0,          0,0,0,          0, 1,2, 1,2,  0,0,1,1, 0,0,16'h0000,0);
    add(1, 1,1,16'h0001,   1,2,16'h0002,   0, 0,1, 1,2,  1,0,0,1, 0,0,16'h0000,0);
    add(1, 1,1,16'h0001,   1,2,16'h0002,   0, 0,1, 1,2,  0,1,0,1, 1,1,16'h0001,0);
    add(1, 1,1,16'h0001,   1,2,16'h0002,   0, 1,1, 1,2,  1,0,1,1, 1,2,16'h0002,0);
    add(1, 1,1,16'h0001,   1,2,16'h0002,   0, 1,2, 1,2,  0,1,1,1, 1,1,16'h0001,0);
    add(1, 0,0,0,          0,0,0,          0, 0,2, 1,2,  0,0,0,1, 1,2,16'h0002,0);
    add(1, 0,0,0,          0,0,0,          0, 0,2, 1,2,  0,0,1,0, 0,2,16'h0002,0);
    // Single write r3 = BEEF.
    add(1, 0,0,0,          0,0,0,          0, 1,3, 3,0,  0,0,1,0, 0,2,16'h0002,0);
    add(1, 1,3,16'hBEEF,   0,0,0,          0, 0,3, 3,0,  1,0,0,1, 0,2,16'h0002,0);
    add(1, 0,0,0,          0,0,0,          0, 0,3, 3,0,  0,0,0,1, 1,3,16'hBEEF,0);
    add(1, 0,0,0,          0,0,0,          0, 0,3, 3,0,  0,0,1,0, 0,3,16'hBEEF,0);
    // WAW on r5 with the commit delayed by wb_hold.
    add(1, 0,0,0,          0,0,0,          0, 1,5, 5,5,  0,0,1,0, 0,3,16'hBEEF,0);
    add(1, 0,0,0,          1,5,16'h1234,   1, 1,5, 5,5,  0,0,0,1, 0,3,16'hBEEF,0);
    add(1, 0,0,0,          1,5,16'h1234,   1, 1,5, 5,5,  0,0,0,1, 0,3,16'hBEEF,0);
    add(1, 0,0,0,          1,5,16'h1234,   0, 1,5, 5,5,  0,1,0,1, 0,3,16'hBEEF,0);
    add(1, 0,0,0,          0,0,0,          0, 1,5, 5,5,  0,0,0,1, 1,5,16'h1234,0);
    add(1, 0,0,0,          0,0,0,          0, 1,5, 5,5,  0,0,1,0, 0,5,16'h1234,0);
    add(1, 1,5,16'h00AA,   0,0,0,          0, 0,5, 5,5,  1,0,0,1, 0,5,16'h1234,0);
    add(1, 0,0,0,          0,0,0,          0, 0,5, 5,5,  0,0,0,1, 1,5,16'h00AA,0);
    add(1, 0,0,0,          0,0,0,          0, 0,5, 5,5,  0,0,1,0, 0,5,16'h00AA,0);
    // Unissued MEM write to r9 raises a sticky sb_err.
    add(1, 0,0,0,          1,9,16'h0099,   0, 0,9, 9,9,  0,1,1,0, 0,5,16'h00AA,0);
    add(1, 0,0,0,          0,0,0,          0, 0,9, 9,9,  0,0,1,0, 1,9,16'h0099,0);
    add(1, 0,0,0,          0,0,0,          0, 0,9, 9,9,  0,0,1,0, 0,9,16'h0099,1);
    add(1, 0,0,0,          0,0,0,          0, 0,9, 9,9,  0,0,1,0, 0,9,16'h0099,1);
    // Reset during an ALU request; the request is re-granted afterwards.
    add(1, 0,0,0,          0,0,0,          0, 1,7, 7,7,  0,0,1,0, 0,9,16'h0099,1);
    add(0, 1,7,16'h7777,   0,0,0,          0, 0,7, 0,0,  0,0,0,0, 0,9,16'h0099,1);
    add(1, 1,7,16'h7777,   0,0,0,          0, 1,7, 7,7,  1,0,1,0, 0,0,16'h0000,0);
    add(1, 0,0,0,          0,0,0,          0, 0,7, 7,7,  0,0,0,1, 1,7,16'h7777,0);
    add(1, 0,0,0,          0,0,0,          0, 0,7, 7,7,  0,0,1,0, 0,7,16'h7777,0);

    // ---- reset with random inputs for two edges ----
    for (int c = 0; c < 2; c++) begin
      rst_n = 1'b0;
      alu_v = 1'($urandom_range(0, 1)); alu_r = AW'($urandom_range(0, 15)); alu_d = DW'($urandom);
      mem_v = 1'($urandom_range(0, 1)); mem_r = AW'($urandom_range(0, 15)); mem_d = DW'($urandom);
      hold  = 1'($urandom_range(0, 1));
      iss_v = 1'($urandom_range(0, 1)); iss_r = AW'($urandom_range(0, 15));
      src1  = AW'($urandom_range(0, 15)); src2 = AW'($urandom_range(0, 15));
      run_cycle(1'b1, (c == 1));
    end

    // ---- scoreboard empty after reset: sweep every register ----
    rst_n = 1'b1; alu_v = 1'b0; mem_v = 1'b0; hold = 1'b0; iss_v = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      iss_r = AW'(r); src1 = AW'(r); src2 = AW'(r);
      run_cycle(1'b1, 1'b1);
    end

    // ---- directed table ----
    foreach (vecs[k]) begin
      rst_n = vecs[k].rst;
      alu_v = vecs[k].av; alu_r = vecs[k].ar; alu_d = vecs[k].ad;
      mem_v = vecs[k].mv; mem_r = vecs[k].mr; mem_d = vecs[k].md;
      hold  = vecs[k].hold;
      iss_v = vecs[k].iv; iss_r = vecs[k].ir;
      src1  = vecs[k].s1; src2  = vecs[k].s2;
      @(negedge clk);
      chk("tbl_alu_ready",   alu_rdy, vecs[k].e_ar);
      chk("tbl_mem_ready",   mem_rdy, vecs[k].e_mr);
      chk("tbl_issue_ready", iss_rdy, vecs[k].e_ir);
      chk("tbl_src_busy",    busy,    vecs[k].e_busy);
      chk("tbl_rf_we",       we,      vecs[k].e_we);
      chk("tbl_rf_reg",      wreg,    vecs[k].e_wreg);
      chk("tbl_rf_data",     wdata,   vecs[k].e_wd);
      chk("tbl_sb_err",      err,     vecs[k].e_err);
      @(posedge clk);
      m_advance();
      cyc++;
      #1;
    end

    // ---- randomized traffic against the model ----
    alu_v = 1'b0; mem_v = 1'b0; last_win = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      if (alu_v && last_win == 1) alu_v = 1'b0;
      if (mem_v && last_win == 2) mem_v = 1'b0;
      if (!alu_v && $urandom_range(0, 2) != 0) begin
        alu_v = 1'b1; alu_r = pick_reg(); alu_d = DW'($urandom);
      end
      if (!mem_v && $urandom_range(0, 2) != 0) begin
        mem_v = 1'b1; mem_r = pick_reg(); mem_d = DW'($urandom);
      end
      hold  = ($urandom_range(0, 4) == 0);
      iss_v = 1'($urandom_range(0, 1));
      iss_r = AW'($urandom_range(0, 15));
      src1  = AW'($urandom_range(0, 15));
      src2  = AW'($urandom_range(0, 15));
      run_cycle(1'b1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
